mem_rsp_credit_buf: RTL and testbench

MEM_RSP_CREDIT_BUF -- requirements
Module: mem_rsp_credit_buf

---
 rtl/mem_rsp_credit_buf.sv | 106 ++++++++++
 tb/tb_mem_rsp_credit_buf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_rsp_credit_buf.sv
// Credit-limited request pass-through with a buffered, back-pressurable response path.
// Optional MEM_RSP_CREDIT_BUF_BYPASS_EN: zero-latency forwarding when the buffer is empty.
module mem_rsp_credit_buf #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int Depth     = 2,
    localparam int StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 up_req_i,
    output logic                 up_gnt_o,
    input  logic [AddrWidth-1:0] up_addr_i,
    input  logic                 up_we_i,
    input  logic [DataWidth-1:0] up_wdata_i,
    input  logic [StrbWidth-1:0] up_strb_i,
    output logic                 up_rvalid_o,
    output logic [DataWidth-1:0] up_rdata_o,
    input  logic                 up_rready_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [StrbWidth-1:0] mem_strb_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 overflow_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CntW-1:0]      cnt, fifo_cnt;
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [DataWidth-1:0] fifo_q [Depth];
    logic                 overflow_q;

    logic credit, fifo_empty, fifo_full, bypass;
    logic push, pop, drop, inc, dec;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit only looks at registered state, so grant never depends on up_rready_i.
    assign credit     = !rst_i && (cnt < CntW'(Depth));
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CntW'(Depth));

    assign mem_req_o   = up_req_i & credit;
    assign up_gnt_o    = mem_gnt_i & credit;
    assign mem_addr_o  = up_addr_i;
    assign mem_we_o    = up_we_i;
    assign mem_wdata_o = up_wdata_i;
    assign mem_strb_o  = up_strb_i;

`ifdef MEM_RSP_CREDIT_BUF_BYPASS_EN
    assign bypass = !rst_i & fifo_empty & mem_rvalid_i & up_rready_i;
`else
    assign bypass = 1'b0;
`endif

    assign up_rvalid_o = !fifo_empty | bypass;
    assign up_rdata_o  = bypass ? mem_rdata_i : fifo_q[rd_ptr];

    assign pop  = !fifo_empty & up_rready_i;
    assign push = mem_rvalid_i & !bypass & (!fifo_full | pop);
    assign drop = mem_rvalid_i & !bypass & fifo_full & !pop;
    assign inc  = mem_req_o & mem_gnt_i;
    assign dec  = up_rvalid_o & up_rready_i;

    assign overflow_o = overflow_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt        <= '0;
            fifo_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (inc && !dec)
                cnt <= cnt + 1'b1;
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - 1'b1;

            if (push && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - 1'b1;

            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);

            // A beat with nothing outstanding, a dropped beat or an underflowing pop is a protocol error.
            if (drop || (dec && cnt == '0) || (mem_rvalid_i && cnt == '0))
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr] <= mem_rdata_i;
    end

endmodule

// File: tb/tb_mem_rsp_credit_buf.sv
// Directed vector table for handshake/credit/reset corners, then a randomized memory model with scoreboard.
module tb_mem_rsp_credit_buf;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int DEPTH = 2;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_req, up_gnt_o, up_we, up_rvalid_o, up_rready;
    logic [AW-1:0] up_addr, mem_addr_o;
    logic [DW-1:0] up_wdata, up_rdata_o, mem_wdata_o, mem_rdata;
    logic [SW-1:0] up_strb, mem_strb_o;
    logic          mem_req_o, mem_gnt, mem_we_o, mem_rvalid, overflow_o;

    always #5 clk = ~clk;

    mem_rsp_credit_buf #(.AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .up_req_i(up_req), .up_gnt_o(up_gnt_o), .up_addr_i(up_addr), .up_we_i(up_we),
        .up_wdata_i(up_wdata), .up_strb_i(up_strb),
        .up_rvalid_o(up_rvalid_o), .up_rdata_o(up_rdata_o), .up_rready_i(up_rready),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .overflow_o(overflow_o)
    );

    typedef struct {
        logic        rst, req, gnt, rv;
        logic [63:0] rdata;
        logic        rr;
        logic        e_mreq, e_ugnt, e_uv;
        logic [63:0] e_data;
        int          e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t        vecs[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_t = 0;
    logic [63:0] pend_d[$];
    int          pend_t[$];
    logic [63:0] sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic rs, rq, gn, rv, input logic [63:0] rd, input logic rr,
                                input logic em, eg, ev, input logic [63:0] ed, input int ec,
                                input logic eo);
        vec_t v;
        v.rst = rs; v.req = rq; v.gnt = gn; v.rv = rv; v.rdata = rd; v.rr = rr;
        v.e_mreq = em; v.e_ugnt = eg; v.e_uv = ev; v.e_data = ed; v.e_cnt = ec; v.e_ovf = eo;
        vecs.push_back(v);
    endfunction

    task automatic rnd_cycle(input bit drain);
        logic [63:0] d;
        int t;
        @(posedge clk); #1;
        up_req    = drain ? 1'b0 : 1'($urandom_range(0, 1));
        mem_gnt   = 1'($urandom_range(0, 1));
        up_rready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        up_addr   = $urandom;
        up_we     = 1'($urandom_range(0, 1));
        up_wdata  = {$urandom, $urandom};
        up_strb   = SW'($urandom);
        if (pend_d.size() > 0 && pend_t[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_d[0];
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        chk("rnd cnt", 64'(dut.cnt), 64'(sb.size()));
        chk("rnd mem_req", 64'(mem_req_o), 64'(up_req && sb.size() < DEPTH));
        chk("rnd up_gnt", 64'(up_gnt_o), 64'(mem_gnt && sb.size() < DEPTH));
        chk("rnd passthru", 64'(mem_addr_o == up_addr && mem_we_o == up_we &&
                                mem_wdata_o == up_wdata && mem_strb_o == up_strb), 64'd1);
        if (up_rvalid_o && up_rready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rnd rvalid: got response %0h, want none", up_rdata_o);
            end else begin
                chk("rnd rdata", up_rdata_o, sb.pop_front());
            end
        end
        if (mem_rvalid) begin
            void'(pend_d.pop_front());
            void'(pend_t.pop_front());
        end
        if (mem_req_o && mem_gnt) begin
            d = {$urandom, $urandom};
            t = cyc + int'($urandom_range(1, 4));
            if (t <= last_t) t = last_t + 1;
            last_t = t;
            pend_d.push_back(d);
            pend_t.push_back(t);
            sb.push_back(d);
        end
        cyc++;
    endtask

    initial begin
        int n;
        rst = 1'b1; up_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; up_rready = 0;
        up_addr = 32'h1234_5678; up_we = 0; up_wdata = '0; up_strb = '0;

        // rst, req, gnt, rv, rdata, rready | mem_req, up_gnt, up_rvalid, up_rdata, cnt, overflow
        add(1,1,1,0,0,1,        0,0,0,0,0,0);
        // three back-to-back reads, latency 1, rready high
`ifdef MEM_RSP_CREDIT_BUF_BYPASS_EN
        add(0,1,1,0,0,1,        1,1,0,0,0,0);
        add(0,1,1,1,'hA,1,      1,1,1,'hA,1,0);
        add(0,1,1,1,'hB,1,      1,1,1,'hB,1,0);
        add(0,0,0,1,'hC,1,      0,0,1,'hC,1,0);
        add(0,0,0,0,0,1,        0,0,0,0,0,0);
`else
        add(0,1,1,0,0,1,        1,1,0,0,0,0);
        add(0,1,1,1,'hA,1,      1,1,0,0,1,0);
        add(0,1,1,1,'hB,1,      0,0,1,'hA,2,0);
        add(0,1,1,0,0,1,        1,1,1,'hB,1,0);
        add(0,0,0,1,'hC,1,      0,0,0,0,1,0);
        add(0,0,0,0,0,1,        0,0,1,'hC,1,0);
        add(0,0,0,0,0,1,        0,0,0,0,0,0);
`endif
        // rready low: credits exhausted, third request waits one cycle past the first pop
        add(0,1,1,0,0,0,        1,1,0,0,0,0);
        add(0,1,1,1,'hD,0,      1,1,0,0,1,0);
        add(0,1,1,1,'hE,0,      0,0,1,'hD,2,0);
        add(0,1,1,0,0,0,        0,0,1,'hD,2,0);
        add(0,1,1,0,0,1,        0,0,1,'hD,2,0);
        add(0,1,1,0,0,0,        1,1,1,'hE,1,0);
        add(0,0,0,1,'hF,1,      0,0,1,'hE,2,0);
        add(0,0,0,0,0,1,        0,0,1,'hF,1,0);
        add(0,0,0,0,0,1,        0,0,0,0,0,0);
        // push and pop together while full
        add(0,1,1,0,0,0,        1,1,0,0,0,0);
        add(0,1,1,1,'h11,0,     1,1,0,0,1,0);
        add(0,0,0,1,'h22,0,     0,0,1,'h11,2,0);
        add(0,0,0,1,'h33,1,     0,0,1,'h11,2,0);
        add(0,0,0,0,0,1,        0,0,1,'h22,1,0);
        add(0,0,0,0,0,0,        0,0,1,'h33,0,0);
        // stray response with nothing outstanding sets sticky overflow
        add(1,1,0,0,0,0,        0,0,0,0,0,0);
        add(0,0,0,1,'h44,0,     0,0,0,0,0,0);
        add(0,0,0,0,0,0,        0,0,1,'h44,0,1);
        add(0,1,0,0,0,0,        1,0,1,'h44,0,1);
        // reset with two buffered responses, then a clean restart
        add(1,0,0,0,0,0,        0,0,0,0,0,0);
        add(0,1,1,0,0,0,        1,1,0,0,0,0);
        add(0,1,1,1,'h55,0,     1,1,0,0,1,0);
        add(0,0,0,1,'h66,0,     0,0,1,'h55,2,0);
        add(1,1,1,0,0,1,        0,0,0,0,0,0);
        add(0,1,1,0,0,1,        1,1,0,0,0,0);
        add(0,0,0,1,'h77,0,     0,0,0,0,1,0);
        add(0,0,0,0,0,1,        0,0,1,'h77,1,0);
        add(0,0,0,0,0,1,        0,0,0,0,0,0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; up_req = vecs[i].req; mem_gnt = vecs[i].gnt;
            mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata; up_rready = vecs[i].rr;
            @(negedge clk);
            chk($sformatf("v%0d mem_req", i), 64'(mem_req_o), 64'(vecs[i].e_mreq));
            chk($sformatf("v%0d up_gnt", i), 64'(up_gnt_o), 64'(vecs[i].e_ugnt));
            chk($sformatf("v%0d up_rvalid", i), 64'(up_rvalid_o), 64'(vecs[i].e_uv));
            if (vecs[i].e_uv) chk($sformatf("v%0d up_rdata", i), up_rdata_o, vecs[i].e_data);
            chk($sformatf("v%0d cnt", i), 64'(dut.cnt), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d overflow", i), 64'(overflow_o), 64'(vecs[i].e_ovf));
        end

        for (int k = 0; k < 10000; k++) rnd_cycle(1'b0);
        n = 0;
        while ((sb.size() > 0 || pend_d.size() > 0) && n < 200) begin
            rnd_cycle(1'b1);
            n++;
        end
        chk("drain scoreboard empty", 64'(sb.size()), 64'd0);
        chk("rnd overflow", 64'(overflow_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
